// File: rtl/button_reader_pkg.sv
// Shared definitions for the pushbutton reader: FSM state type, state
// encodings and the default timing constants (10 kHz oscillator).
package button_reader_pkg;

  // 10 ms of stable samples at 10 kHz before a level change is accepted
  localparam int DEFAULT_DEBOUNCE_CYCLES   = 100;

  // 1 s of hold time at 10 kHz before a press counts as long
  localparam int DEFAULT_LONG_PRESS_CYCLES = 10000;

  // Explicit encodings so the state register is easy to read in waveforms
  localparam logic [1:0] ENC_IDLE        = 2'd0;
  localparam logic [1:0] ENC_DEB_PRESS   = 2'd1;
  localparam logic [1:0] ENC_PRESSED     = 2'd2;
  localparam logic [1:0] ENC_DEB_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE        = ENC_IDLE,
    ST_DEB_PRESS   = ENC_DEB_PRESS,
    ST_PRESSED     = ENC_PRESSED,
    ST_DEB_RELEASE = ENC_DEB_RELEASE
  } state_t;

  // Width needed for a counter that must be able to hold maxCount itself
  function automatic int counterWidth(input int maxCount);
    return $clog2(maxCount + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both flops clear to 0 on the asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/button_reader.sv
// Pushbutton reader: synchronizes a raw button, debounces both edges,
// measures hold time and reports each completed press as a short/long
// event through a valid/ack holding register.
// Optional feature macro: BUTTON_READER_OVERRUN_FLAG_EN adds a sticky
// evt_overrun output that records an event dropped while one was pending.
module button_reader
  import button_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic press_active,
  output logic evt_valid,
  output logic evt_long,
  input  logic evt_ack
`ifdef BUTTON_READER_OVERRUN_FLAG_EN
  ,
  output logic evt_overrun
`endif
);

  localparam int DW = counterWidth(DEBOUNCE_CYCLES);
  localparam int HW = counterWidth(LONG_PRESS_CYCLES);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE   = DW'(1);
  localparam logic [DW-1:0] DB_ZERO  = '0;
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO = '0;

  // Parameter sanity: the debounce window needs at least one sample and a
  // long press must outlast the debounce window to be meaningful.
  generate
    if (DEBOUNCE_CYCLES < 1) begin : g_badDebounce
      $error("button_reader: DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_badLongPress
      $error("button_reader: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
    end
  endgenerate

  // Synchronized button; the FSM never looks at btn_in directly
  logic w_sync;

  state_t r_state;
  state_t w_nextState;

  logic [DW-1:0] r_dbCount;
  logic [DW-1:0] w_dbCountNext;
  logic [HW-1:0] r_holdCount;
  logic [HW-1:0] w_holdCountNext;
  logic [HW-1:0] w_holdInc;
  logic          r_btnLevel;
  logic          w_btnLevelNext;

  // Completed-press strobe and its class, both valid for one cycle
  logic w_evtFire;
  logic w_evtLongNew;

  logic r_evtValid;
  logic r_evtLong;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (btn_in),
    .o_q   (w_sync)
  );

  // Hold counter saturates so very long presses can never wrap back to short
  assign w_holdInc    = (r_holdCount == HOLD_MAX) ? r_holdCount : (r_holdCount + HOLD_ONE);
  assign w_evtLongNew = (r_holdCount == HOLD_MAX);

  // Next-state and counter update logic for the debounce/hold FSM
  always_comb begin
    w_nextState     = r_state;
    w_dbCountNext   = r_dbCount;
    w_holdCountNext = r_holdCount;
    w_btnLevelNext  = r_btnLevel;
    w_evtFire       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_sync) begin
          w_nextState   = ST_DEB_PRESS;
          w_dbCountNext = DB_ZERO;
        end
      end

      ST_DEB_PRESS: begin
        if (!w_sync) begin
          w_nextState = ST_IDLE;
        end else if (r_dbCount == DB_LAST) begin
          w_nextState     = ST_PRESSED;
          w_btnLevelNext  = 1'b1;
          w_holdCountNext = HOLD_ZERO;
        end else begin
          w_dbCountNext = r_dbCount + DB_ONE;
        end
      end

      ST_PRESSED: begin
        w_holdCountNext = w_holdInc;
        if (!w_sync) begin
          w_nextState   = ST_DEB_RELEASE;
          w_dbCountNext = DB_ZERO;
        end
      end

      ST_DEB_RELEASE: begin
        // A release glitch keeps the hold time accumulated so far
        w_holdCountNext = w_holdInc;
        if (w_sync) begin
          w_nextState = ST_PRESSED;
        end else if (r_dbCount == DB_LAST) begin
          w_nextState    = ST_IDLE;
          w_btnLevelNext = 1'b0;
          w_evtFire      = 1'b1;
        end else begin
          w_dbCountNext = r_dbCount + DB_ONE;
        end
      end

      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // FSM state, counters and debounced level register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_dbCount   <= DB_ZERO;
      r_holdCount <= HOLD_ZERO;
      r_btnLevel  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_dbCount   <= w_dbCountNext;
      r_holdCount <= w_holdCountNext;
      r_btnLevel  <= w_btnLevelNext;
    end
  end

  // Event holding register: load when empty or being acked, else drop new event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evtValid <= 1'b0;
      r_evtLong  <= 1'b0;
    end else if (w_evtFire && (!r_evtValid || evt_ack)) begin
      r_evtValid <= 1'b1;
      r_evtLong  <= w_evtLongNew;
    end else if (r_evtValid && evt_ack) begin
      r_evtValid <= 1'b0;
    end
  end

`ifdef BUTTON_READER_OVERRUN_FLAG_EN
  logic r_evtOverrun;

  // Sticky record that a completed press was lost because nobody acked in time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evtOverrun <= 1'b0;
    end else if (w_evtFire && r_evtValid && !evt_ack) begin
      r_evtOverrun <= 1'b1;
    end
  end

  assign evt_overrun = r_evtOverrun;
`else
  // Without the overrun flag a press completed while an event is still
  // pending is simply discarded by the holding register above.
`endif

  assign btn_level    = r_btnLevel;
  assign press_active = (r_state != ST_IDLE);
  assign evt_valid    = r_evtValid;
  assign evt_long     = r_evtLong;

endmodule

// File: tb/tb_button_reader.sv
// Testbench for button_reader with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
// Expected event classes are queued when a press is released; a monitor
// pops and compares each time the DUT presents a new event.
// Define BUTTON_READER_OVERRUN_FLAG_EN to also exercise evt_overrun.
module tb_button_reader;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_in;
  logic evt_ack;
  logic btn_level;
  logic press_active;
  logic evt_valid;
  logic evt_long;
`ifdef BUTTON_READER_OVERRUN_FLAG_EN
  logic evt_overrun;
`endif

  int checks = 0;
  int errors = 0;

  bit expQ[$];
  bit monNew = 1'b1;
  bit monExp;

  always #5 clk = ~clk;

  button_reader #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_active (press_active),
    .evt_valid    (evt_valid),
    .evt_long     (evt_long),
    .evt_ack      (evt_ack)
`ifdef BUTTON_READER_OVERRUN_FLAG_EN
    ,
    .evt_overrun  (evt_overrun)
`endif
  );

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Hold the button for 'hold' cycles, release, wait past the release
  // debounce, optionally ack, and report whether level/activity were seen.
  task automatic applyStimulus(input int hold, input bit expectEvt, input bit expLong,
                               input bit doAck, output bit sawLevel, output bit sawActive);
    sawLevel  = 1'b0;
    sawActive = 1'b0;
    btn_in = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (btn_level)    sawLevel  = 1'b1;
      if (press_active) sawActive = 1'b1;
    end
    btn_in = 1'b0;
    if (expectEvt) expQ.push_back(expLong);
    repeat (DEB + 3) begin
      @(negedge clk);
      if (btn_level)    sawLevel  = 1'b1;
      if (press_active) sawActive = 1'b1;
    end
    if (doAck) begin
      evt_ack = 1'b1;
      @(negedge clk);
      evt_ack = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: a valid seen after an idle or handshaken cycle is a new event
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      monNew = 1'b1;
    end else begin
      if (evt_valid && monNew) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: got evt_valid=1 evt_long=%b, expected no event at %0t",
                   evt_long, $time);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("event_class", evt_long, monExp);
        end
      end
      monNew = !evt_valid || evt_ack;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawLevel;
    bit sawActive;
    bit levelHeld;

    rst_n   = 1'b0;
    btn_in  = 1'b0;
    evt_ack = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_btn_level", btn_level, 1'b0);
    checkOutput("reset_press_active", press_active, 1'b0);
    checkOutput("reset_evt_valid", evt_valid, 1'b0);
    checkOutput("reset_evt_long", evt_long, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean 12-cycle press with latency checks on both edges
    $display("[TB] clean press");
    btn_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 6) checkOutput("press_latency_early", btn_level, 1'b0);
      if (k == 7) checkOutput("press_latency", btn_level, 1'b1);
    end
    btn_in = 1'b0;
    expQ.push_back(1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) begin
        checkOutput("release_latency_early", btn_level, 1'b1);
        checkOutput("evt_before_release", evt_valid, 1'b0);
      end
      if (k == 7) begin
        checkOutput("release_latency", btn_level, 1'b0);
        checkOutput("evt_with_release", evt_valid, 1'b1);
        checkOutput("clean_short", evt_long, 1'b0);
      end
    end
    evt_ack = 1'b1;
    @(negedge clk);
    evt_ack = 1'b0;
    checkOutput("ack_clears", evt_valid, 1'b0);
    evt_ack = 1'b1;
    repeat (2) @(negedge clk);
    evt_ack = 1'b0;
    checkOutput("idle_ack_ignored", evt_valid, 1'b0);

    // Bounce: 3 cycles is too short to be accepted
    $display("[TB] bounce");
    applyStimulus(3, 1'b0, 1'b0, 1'b0, sawLevel, sawActive);
    checkOutput("bounce_level", sawLevel, 1'b0);
    checkOutput("bounce_active_pulse", sawActive, 1'b1);
    checkOutput("bounce_active_end", press_active, 1'b0);
    checkOutput("bounce_no_event", evt_valid, 1'b0);

    // Debounce boundary: 4 samples rejected, 5 accepted
    applyStimulus(4, 1'b0, 1'b0, 1'b0, sawLevel, sawActive);
    checkOutput("hold4_rejected", sawLevel, 1'b0);
    applyStimulus(5, 1'b1, 1'b0, 1'b1, sawLevel, sawActive);
    checkOutput("hold5_accepted", sawLevel, 1'b1);

    // Long-press boundary and a clearly long press
    $display("[TB] long press");
    applyStimulus(20, 1'b1, 1'b0, 1'b1, sawLevel, sawActive);
    applyStimulus(21, 1'b1, 1'b1, 1'b1, sawLevel, sawActive);
    applyStimulus(40, 1'b1, 1'b1, 1'b1, sawLevel, sawActive);
    checkOutput("long_acked", evt_valid, 1'b0);

    // Release glitch: level held, hold time keeps accumulating across it
    $display("[TB] release glitch");
    btn_in = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("glitch_pre_level", btn_level, 1'b1);
    levelHeld = 1'b1;
    btn_in = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (!btn_level) levelHeld = 1'b0;
    end
    btn_in = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!btn_level) levelHeld = 1'b0;
    end
    btn_in = 1'b0;
    expQ.push_back(1'b1);
    repeat (DEB + 3) @(negedge clk);
    checkOutput("glitch_level_held", levelHeld, 1'b1);
    checkOutput("glitch_one_event", evt_valid, 1'b1);
    evt_ack = 1'b1;
    @(negedge clk);
    evt_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Overrun: second event dropped while first is pending
    $display("[TB] overrun");
    applyStimulus(40, 1'b1, 1'b1, 1'b0, sawLevel, sawActive);
    applyStimulus(12, 1'b0, 1'b0, 1'b0, sawLevel, sawActive);
    checkOutput("pending_kept_valid", evt_valid, 1'b1);
    checkOutput("pending_kept_class", evt_long, 1'b1);
`ifdef BUTTON_READER_OVERRUN_FLAG_EN
    checkOutput("overrun_set", evt_overrun, 1'b1);
`endif
    evt_ack = 1'b1;
    @(negedge clk);
    evt_ack = 1'b0;
    checkOutput("overrun_ack_clears", evt_valid, 1'b0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef BUTTON_READER_OVERRUN_FLAG_EN
    checkOutput("overrun_cleared_by_reset", evt_overrun, 1'b0);
`endif

    // Ack on the same edge as a new event: new event loaded, valid stays 1
    applyStimulus(40, 1'b1, 1'b1, 1'b0, sawLevel, sawActive);
    btn_in = 1'b1;
    repeat (12) @(negedge clk);
    btn_in = 1'b0;
    expQ.push_back(1'b0);
    repeat (DEB + 2) @(negedge clk);
    evt_ack = 1'b1;
    @(negedge clk);
    evt_ack = 1'b0;
    checkOutput("ack_and_new_valid", evt_valid, 1'b1);
    checkOutput("ack_and_new_class", evt_long, 1'b0);
`ifdef BUTTON_READER_OVERRUN_FLAG_EN
    checkOutput("ack_and_new_no_overrun", evt_overrun, 1'b0);
`endif
    evt_ack = 1'b1;
    @(negedge clk);
    evt_ack = 1'b0;
    checkOutput("second_ack_clears", evt_valid, 1'b0);
    repeat (2) @(negedge clk);

    // Reset mid-press with a long event pending: everything clears at once
    $display("[TB] reset mid-press");
    applyStimulus(40, 1'b1, 1'b1, 1'b0, sawLevel, sawActive);
    btn_in = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("pre_reset_level", btn_level, 1'b1);
    checkOutput("pre_reset_valid", evt_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_now_btn_level", btn_level, 1'b0);
    checkOutput("reset_now_press_active", press_active, 1'b0);
    checkOutput("reset_now_evt_valid", evt_valid, 1'b0);
    checkOutput("reset_now_evt_long", evt_long, 1'b0);
    btn_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sawLevel = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (btn_level || press_active) sawLevel = 1'b1;
    end
    checkOutput("no_press_after_reset", sawLevel, 1'b0);

    // Button held through reset release debounces normally
    btn_in = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 6) checkOutput("held_reset_rise_early", btn_level, 1'b0);
      if (k == 7) checkOutput("held_reset_rise", btn_level, 1'b1);
    end
    btn_in = 1'b0;
    expQ.push_back(1'b0);
    repeat (DEB + 3) @(negedge clk);
    checkOutput("held_reset_event", evt_valid, 1'b1);
    evt_ack = 1'b1;
    @(negedge clk);
    evt_ack = 1'b0;

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", expQ.size() == 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
